// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    // Bit positions inside the [Z,V,N] flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two requesters, the consumer and the arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
);
    logic               req0_valid;
    logic               req0_ready;
    logic [2:0]         req0_op;
    logic [DATA_W-1:0]  req0_a;
    logic [DATA_W-1:0]  req0_b;
    logic [SHAMT_W-1:0] req0_shamt;
    logic               req0_setf;

    logic               req1_valid;
    logic               req1_ready;
    logic [2:0]         req1_op;
    logic [DATA_W-1:0]  req1_a;
    logic [DATA_W-1:0]  req1_b;
    logic [SHAMT_W-1:0] req1_shamt;
    logic               req1_setf;

    logic               rsp_valid;
    logic               rsp_id;
    logic [DATA_W-1:0]  rsp_result;
    logic               rsp_ready;

    // Requester / response-consumer side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_shamt, req0_setf,
        output req1_valid, req1_op, req1_a, req1_b, req1_shamt, req1_setf,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_shamt, req0_setf,
        input  req1_valid, req1_op, req1_a, req1_b, req1_shamt, req1_setf,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_flag_calc.sv
// Combinational [Z,V,N] computation from opcode, operands and ALU result.
// flag_we_mask marks which flag bits this opcode is allowed to write.
module alu_flag_calc
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] r,
    output logic [2:0]        next_flags,
    output logic [2:0]        flag_we_mask
);

    logic zero;
    logic sa, sb, sr;

    assign zero = (r == '0);
    assign sa   = a[DATA_W-1];
    assign sb   = b[DATA_W-1];
    assign sr   = r[DATA_W-1];

    // Per-opcode flag values; shifts leave every flag untouched
    always_comb begin
        next_flags   = 3'b000;
        flag_we_mask = 3'b111;
        case (op)
            OP_ADD, OP_INC: begin
                next_flags[FLAG_Z] = zero;
                next_flags[FLAG_V] = (sa == sb) && (sr != sa);
                next_flags[FLAG_N] = sr;
            end
            OP_SUB: begin
                next_flags[FLAG_Z] = zero;
                next_flags[FLAG_V] = (sa != sb) && (sr != sa);
                next_flags[FLAG_N] = sr;
            end
            OP_NAND, OP_XOR: begin
                next_flags[FLAG_Z] = zero;
            end
            default: begin
                flag_we_mask = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: IDLE (grant) -> EXEC (drive ALU, capture) -> RESP (hold).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int         DATA_W   = 16,
    parameter int         SHAMT_W  = 4,
    parameter logic [2:0] FLAG_RST = 3'b000
) (
    input  logic               clk,
    input  logic               rst,
    alu_arbiter_if.slave       bus,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SHAMT_W-1:0] alu_shift,
    output logic [2:0]         alu_ctrl,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [2:0]         flags,
    output logic               busy
);

    state_t              state;
    logic                last_grant;
    logic                op_id;
    logic                op_setf;
    logic                grant0, grant1;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic [2:0]          next_flags;
    logic [2:0]          flag_we_mask;

    // Grant only in IDLE; on contention the port that did not win last time goes
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || last_grant))
                grant0 = 1'b1;
            else if (bus.req1_valid)
                grant1 = 1'b1;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign busy           = (state != IDLE);

    // The alu_* registers double as the operation register, so they hold outside EXEC
    alu_flag_calc #(.DATA_W(DATA_W)) u_flag_calc (
        .op           (alu_ctrl),
        .a            (alu_a),
        .b            (alu_b),
        .r            (alu_result),
        .next_flags   (next_flags),
        .flag_we_mask (flag_we_mask)
    );

    // FSM, operation latch, response register and flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            op_id        <= 1'b0;
            op_setf      <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_shift    <= '0;
            alu_ctrl     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            flags        <= FLAG_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_a      <= grant1 ? bus.req1_a     : bus.req0_a;
                        alu_b      <= grant1 ? bus.req1_b     : bus.req0_b;
                        alu_shift  <= grant1 ? bus.req1_shamt : bus.req0_shamt;
                        alu_ctrl   <= grant1 ? bus.req1_op    : bus.req0_op;
                        op_setf    <= grant1 ? bus.req1_setf  : bus.req0_setf;
                        op_id      <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_id_q     <= op_id;
                    rsp_valid_q  <= 1'b1;
                    if (op_setf)
                        flags <= (flags & ~flag_we_mask) | (next_flags & flag_we_mask);
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int         DATA_W  = 16;
    localparam int         SHAMT_W = 4;
    localparam logic [2:0] FRST    = 3'b101;

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_W-1:0]  alu_a, alu_b, alu_result;
    logic [SHAMT_W-1:0] alu_shift;
    logic [2:0]         alu_ctrl;
    logic [2:0]         flags;
    logic               busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

    alu_arbiter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .FLAG_RST(FRST)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shift  (alu_shift),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .flags      (flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU shared by both ports
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_NAND: alu_result = ~(alu_a & alu_b);
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_INC:  alu_result = alu_a + 16'd1;
            OP_SRA:  alu_result = $signed(alu_a) >>> alu_shift;
            OP_SRL:  alu_result = alu_a >> alu_shift;
            default: alu_result = alu_a << alu_shift;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int port, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh, input logic setf);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a;
            bus.req0_b = b; bus.req0_shamt = sh; bus.req0_setf = setf;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a;
            bus.req1_b = b; bus.req1_shamt = sh; bus.req1_setf = setf;
        end
    endtask

    // One uncontended op: grant, EXEC, then check the response in RESP
    task automatic single(input string tag, input int port, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh, input logic setf,
                          input logic [15:0] exp_r, input logic [2:0] exp_f);
        @(negedge clk);
        drive(port, 1'b1, op, a, b, sh, setf);
        #1;
        chk({tag, "_ready"}, {30'd0, bus.req1_ready, bus.req0_ready},
            (port == 0) ? 32'd1 : 32'd2);
        @(negedge clk);
        if (port == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        #1;
        chk({tag, "_exec"}, {busy, bus.rsp_valid, alu_ctrl}, {1'b1, 1'b0, op});
        @(negedge clk);
        #1;
        chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_result},
            {1'b1, port[0], exp_r});
        chk({tag, "_flags"}, flags, exp_f);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 3'd0, 16'h0, 16'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 3'd0, 16'h0, 16'h0, 4'h0, 1'b0);
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, 32'd0);
        chk("rst_flags", flags, FRST);
        chk("rst_busy_ready", {busy, bus.req0_ready, bus.req1_ready}, 32'd0);
        chk("rst_alu", {alu_a, alu_b, alu_shift, alu_ctrl}, 39'd0);
        rst = 1'b0;

        // SLL leaves the reset flags 101 alone
        single("sll", 0, OP_SLL, 16'h0001, 16'h0000, 4'd15, 1'b1, 16'h8000, 3'b101);
        // Signed overflow on ADD
        single("add_ovf", 0, OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 1'b1, 16'h8000, 3'b011);
        // setf=0 keeps flags; port 1 so last_grant ends at 1
        single("add_nof", 1, OP_ADD, 16'h0001, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 3'b011);

        // Contention: port 0 first, then port 1
        @(negedge clk);
        drive(0, 1'b1, OP_SUB, 16'h0005, 16'h0005, 4'd0, 1'b1);
        drive(1, 1'b1, OP_XOR, 16'hFFFF, 16'h0000, 4'd0, 1'b1);
        #1;
        chk("rr1_ready", {bus.req1_ready, bus.req0_ready}, 32'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("rr1_exec_noready", {bus.req1_ready, bus.req0_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("rr1_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 1'b0, 16'h0000});
        chk("rr1_flags", flags, 3'b100);
        @(negedge clk);
        #1;
        chk("rr2_ready", {bus.req1_ready, bus.req0_ready}, 32'd2);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rr2_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 1'b1, 16'hFFFF});
        chk("rr2_flags", flags, 3'b000);

        // Third pair goes to port 0; then hold the response
        @(negedge clk);
        drive(0, 1'b1, OP_NAND, 16'hFFFF, 16'hFFFF, 4'd0, 1'b1);
        drive(1, 1'b1, OP_INC, 16'h7FFF, 16'h0001, 4'd0, 1'b1);
        #1;
        chk("rr3_ready", {bus.req1_ready, bus.req0_ready}, 32'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, OP_SUB, 16'h0000, 16'h0001, 4'd0, 1'b1);
        #1;
        chk("rr3_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 1'b0, 16'h0000});
        chk("rr3_flags", flags, 3'b100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("hold", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, busy, bus.rsp_result},
                {1'b0, 1'b0, 1'b1, 1'b1, 16'h0000});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("after_hold_ready", {bus.req1_ready, bus.req0_ready}, 32'd2);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("inc_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 1'b1, 16'h8000});
        chk("inc_flags", flags, 3'b011);

        // Reset during EXEC of a SUB
        @(negedge clk);
        #1;
        chk("sub_ready", {bus.req1_ready, bus.req0_ready}, 32'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("sub_exec", {busy, alu_ctrl}, {1'b1, OP_SUB});
        rst = 1'b1;
        #1;
        chk("midrst_state", {bus.rsp_valid, busy, bus.req0_ready, bus.req1_ready}, 32'd0);
        chk("midrst_flags", flags, FRST);
        @(negedge clk);
        rst = 1'b0;

        single("post_rst", 0, OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 1'b1, 16'h8000, 3'b011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
